// File: rtl/sipo_rx.sv
// LSB-first serial-to-parallel word receiver with start framing, gap-tolerant
// bit counting, and a valid/ready output handshake with overrun/frame-error pulses.
//
// state | meaning
// IDLE  | waiting for frame_start; stray shift_en is ignored
// RECV  | word in progress; count holds the number of bits captured so far
module sipo_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             shift_en,
    input  logic             frame_start,
    input  logic             out_ready,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic [WIDTH-1:0] parallel_nxt;
    logic             valid_nxt;
    logic             overrun_nxt;
    logic             frame_err_nxt;
    logic             capture;
    logic             complete;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            shreg        <= '0;
            count        <= '0;
            parallel_out <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_nxt;
            shreg        <= shreg_nxt;
            count        <= count_nxt;
            parallel_out <= parallel_nxt;
            out_valid    <= valid_nxt;
            overrun      <= overrun_nxt;
            frame_err    <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        count_nxt     = count;
        parallel_nxt  = parallel_out;
        valid_nxt     = out_valid;
        overrun_nxt   = 1'b0;
        frame_err_nxt = 1'b0;
        capture       = 1'b0;
        complete      = 1'b0;

        // frame_start restarts the word from either state; a partial word is dropped.
        if (frame_start) begin
            frame_err_nxt = (state == RECV) && (count != '0);
            capture       = shift_en;
            state_nxt     = RECV;
            shreg_nxt     = shift_en ? {serial_in, {(WIDTH-1){1'b0}}} : '0;
            count_nxt     = shift_en ? CW'(1) : '0;
        end else if (state == RECV) begin
            capture = shift_en;
            if (shift_en) begin
                shreg_nxt = {serial_in, shreg[WIDTH-1:1]};
                count_nxt = count + CW'(1);
            end
        end

        complete = capture && (count_nxt == CW'(WIDTH));

        if (complete) begin
            parallel_nxt = shreg_nxt;
            valid_nxt    = 1'b1;
            overrun_nxt  = out_valid && !out_ready;
            count_nxt    = '0;
            state_nxt    = IDLE;
        end else if (out_valid && out_ready) begin
            valid_nxt = 1'b0;
        end
    end

    assign busy = (state == RECV);

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx (WIDTH = 4); each scenario task checks the packed
// observation {busy, out_valid, overrun, frame_err, parallel_out} after each edge.
module tb_sipo_rx;

    logic       clk;
    logic       rst;
    logic       serial_in;
    logic       shift_en;
    logic       frame_start;
    logic       out_ready;
    logic [3:0] parallel_out;
    logic       out_valid;
    logic       busy;
    logic       overrun;
    logic       frame_err;
    logic [7:0] st;

    int total = 0;
    int bad   = 0;

    sipo_rx #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .shift_en     (shift_en),
        .frame_start  (frame_start),
        .out_ready    (out_ready),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun),
        .frame_err    (frame_err)
    );

    assign st = {busy, out_valid, overrun, frame_err, parallel_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample 1ns after the rising edge.
    task automatic tick(input logic fs, input logic se, input logic si, input logic rdy);
        frame_start = fs;
        shift_en    = se;
        serial_in   = si;
        out_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (st !== 8'h00) begin bad++; $display("FAIL reset_async: got %h want %h", st, 8'h00); end
        tick(1, 1, 1, 1);
        total++;
        if (st !== 8'h00) begin bad++; $display("FAIL reset_held: got %h want %h", st, 8'h00); end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] bits;
        bits = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            tick(i == 0, 1, bits[i], 0);
            total++;
            if (i < 3 && st !== 8'h80) begin bad++; $display("FAIL basic_bit%0d: got %h want %h", i, st, 8'h80); end
            if (i == 3 && st !== 8'h4B) begin bad++; $display("FAIL basic_done: got %h want %h", st, 8'h4B); end
        end
        tick(0, 0, 0, 1);
        total++;
        if (st !== 8'h0B) begin bad++; $display("FAIL basic_accept: got %h want %h", st, 8'h0B); end
    endtask

    task automatic test_gapped();
        logic [3:0] bits;
        bits = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            tick(i == 0, 1, bits[i], 0);
            total++;
            if (i < 3 && st !== 8'h8B) begin bad++; $display("FAIL gap_bit%0d: got %h want %h", i, st, 8'h8B); end
            if (i == 3 && st !== 8'h4B) begin bad++; $display("FAIL gap_done: got %h want %h", st, 8'h4B); end
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    tick(0, 0, 1, 0);
                    total++;
                    if (st !== 8'h8B) begin bad++; $display("FAIL gap_hold%0d_%0d: got %h want %h", i, g, st, 8'h8B); end
                end
            end
        end
        tick(0, 0, 0, 1);
        total++;
        if (st !== 8'h0B) begin bad++; $display("FAIL gap_accept: got %h want %h", st, 8'h0B); end
    endtask

    task automatic test_overrun();
        logic [3:0] w;
        w = 4'hB;
        for (int i = 0; i < 4; i++) tick(i == 0, 1, w[i], 0);
        total++;
        if (st !== 8'h4B) begin bad++; $display("FAIL ovr_first: got %h want %h", st, 8'h4B); end
        w = 4'h6;
        for (int i = 0; i < 4; i++) begin
            tick(i == 0, 1, w[i], 0);
            total++;
            if (i < 3 && st !== 8'hCB) begin bad++; $display("FAIL ovr_bit%0d: got %h want %h", i, st, 8'hCB); end
            if (i == 3 && st !== 8'h66) begin bad++; $display("FAIL ovr_pulse: got %h want %h", st, 8'h66); end
        end
        tick(0, 0, 0, 0);
        total++;
        if (st !== 8'h46) begin bad++; $display("FAIL ovr_pulse_end: got %h want %h", st, 8'h46); end
        w = 4'h9;
        for (int i = 0; i < 4; i++) begin
            tick(i == 0, 1, w[i], i == 3);
            total++;
            if (i < 3 && st !== 8'hC6) begin bad++; $display("FAIL ovr_rdy_bit%0d: got %h want %h", i, st, 8'hC6); end
            if (i == 3 && st !== 8'h49) begin bad++; $display("FAIL ovr_rdy_done: got %h want %h", st, 8'h49); end
        end
        tick(0, 0, 0, 1);
        total++;
        if (st !== 8'h09) begin bad++; $display("FAIL ovr_accept: got %h want %h", st, 8'h09); end
    endtask

    task automatic test_frame_err();
        logic [3:0] w;
        tick(1, 1, 1, 0);
        tick(0, 1, 0, 0);
        total++;
        if (st !== 8'h89) begin bad++; $display("FAIL ferr_partial: got %h want %h", st, 8'h89); end
        w = 4'hC;
        for (int i = 0; i < 4; i++) begin
            tick(i == 0, 1, w[i], 0);
            total++;
            if (i == 0 && st !== 8'h99) begin bad++; $display("FAIL ferr_pulse: got %h want %h", st, 8'h99); end
            if ((i == 1 || i == 2) && st !== 8'h89) begin bad++; $display("FAIL ferr_bit%0d: got %h want %h", i, st, 8'h89); end
            if (i == 3 && st !== 8'h4C) begin bad++; $display("FAIL ferr_done: got %h want %h", st, 8'h4C); end
        end
        // frame_start while RECV holds zero bits must not flag an error
        tick(1, 0, 0, 0);
        total++;
        if (st !== 8'hCC) begin bad++; $display("FAIL ferr_empty_start: got %h want %h", st, 8'hCC); end
        tick(1, 0, 0, 0);
        total++;
        if (st !== 8'hCC) begin bad++; $display("FAIL ferr_empty_restart: got %h want %h", st, 8'hCC); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] w;
        tick(0, 1, 1, 0);
        tick(0, 1, 1, 0);
        total++;
        if (st !== 8'hCC) begin bad++; $display("FAIL rstmid_pre: got %h want %h", st, 8'hCC); end
        rst = 1'b0;
        #2;
        total++;
        if (st !== 8'h00) begin bad++; $display("FAIL rstmid_async: got %h want %h", st, 8'h00); end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(0, 1, 1, 0);
            total++;
            if (st !== 8'h00) begin bad++; $display("FAIL rstmid_ignore%0d: got %h want %h", i, st, 8'h00); end
        end
        w = 4'h5;
        for (int i = 0; i < 4; i++) tick(i == 0, 1, w[i], 0);
        total++;
        if (st !== 8'h45) begin bad++; $display("FAIL rstmid_word: got %h want %h", st, 8'h45); end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 0);
            total++;
            if (st !== 8'h45) begin bad++; $display("FAIL hold_cyc%0d: got %h want %h", i, st, 8'h45); end
        end
        tick(0, 0, 0, 1);
        total++;
        if (st !== 8'h05) begin bad++; $display("FAIL hold_accept: got %h want %h", st, 8'h05); end
        tick(0, 0, 0, 0);
        total++;
        if (st !== 8'h05) begin bad++; $display("FAIL hold_after: got %h want %h", st, 8'h05); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] w;
        w = 4'hA;
        for (int i = 0; i < 4; i++) begin
            tick(i == 0, 1, w[i], 1);
            total++;
            if (i < 3 && st !== 8'h85) begin bad++; $display("FAIL b2b_a_bit%0d: got %h want %h", i, st, 8'h85); end
            if (i == 3 && st !== 8'h4A) begin bad++; $display("FAIL b2b_a_done: got %h want %h", st, 8'h4A); end
        end
        w = 4'h3;
        for (int i = 0; i < 4; i++) begin
            tick(i == 0, 1, w[i], 1);
            total++;
            if (i < 3 && st !== 8'h8A) begin bad++; $display("FAIL b2b_b_bit%0d: got %h want %h", i, st, 8'h8A); end
            if (i == 3 && st !== 8'h43) begin bad++; $display("FAIL b2b_b_done: got %h want %h", st, 8'h43); end
        end
        tick(0, 0, 0, 1);
        total++;
        if (st !== 8'h03) begin bad++; $display("FAIL b2b_accept: got %h want %h", st, 8'h03); end
    endtask

    initial begin
        rst         = 1'b0;
        serial_in   = 1'b0;
        shift_en    = 1'b0;
        frame_start = 1'b0;
        out_ready   = 1'b0;
        test_reset();
        test_basic();
        test_gapped();
        test_overrun();
        test_frame_err();
        test_reset_mid();
        test_hold();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in/parallel-out receiver that reassembles LSB-first serial words into WIDTH-bit parallel words. It is the receive-side counterpart of the team's parallel-in/serial-out shift register, which shifts right and emits bit 0 first. The block frames each word with a start strobe, counts bits under a per-cycle shift enable, and presents each completed word on a valid/ready output handshake with overrun and frame-error reporting.

## Interface

- WIDTH, default 4, word width in bits; legal range is WIDTH >= 2.
- clk  input  1  clock; every register updates on its rising edge.
- rst  input  1  reset, asynchronous and active-low; clears all state immediately.
- serial_in  input  1  serial data bit; sampled only when shift_en = 1.
- shift_en  input  1  sample strobe; serial_in is captured at this clock edge.
- frame_start  input  1  marks the start of a new word (see Operation).
- out_ready  input  1  consumer accepts parallel_out at an edge where out_valid = 1.
- parallel_out  output  WIDTH  last completed word; bit 0 is the first bit received.
- out_valid  output  1  parallel_out holds an unaccepted word.
- busy  output  1  a word is partially received (state RECV).
- overrun  output  1  one-cycle pulse: an unaccepted word was overwritten.
- frame_err  output  1  one-cycle pulse: a partial word was discarded by frame_start.

## Operation

- Internal state: FSM {IDLE, RECV}, WIDTH-bit shift register, bit counter of width $clog2(WIDTH+1).
- Shift rule (LSB-first): shreg <= {serial_in, shreg[WIDTH-1:1]}. After WIDTH shifts, shreg[0] is the first bit received.
- IDLE:
  - shift_en without frame_start is ignored.
  - frame_start with shift_en = 1: capture bit 0, count = 1, go to RECV.
  - frame_start with shift_en = 0: count = 0, go to RECV.
- RECV:
  - Each shift_en captures one bit and increments count.
  - Cycles without shift_en hold state; gaps of any length are legal.
- Completion: the edge that captures the WIDTH-th bit loads parallel_out with the assembled word, sets out_valid = 1, clears count, and returns to IDLE. The next word requires a new frame_start.
- frame_start in RECV:
  - The partial word is discarded and the new-word rules from IDLE apply on the same edge.
  - frame_err pulses for one cycle if count > 0. No pulse if count = 0.
- Output handshake:
  - out_valid clears at an edge where out_valid = 1, out_ready = 1, and no completion occurs.
  - Completion with out_valid = 1 and out_ready = 0: parallel_out is overwritten, out_valid stays 1, overrun pulses for one cycle.
  - Completion with out_valid = 1 and out_ready = 1: the old word is accepted, the new word is loaded, out_valid stays 1, and no overrun occurs.
- busy = 1 exactly when state = RECV.
- parallel_out changes only on a completion edge; it holds its value after acceptance.

## Timing

- Reset (rst = 0, asynchronous) sets: parallel_out = 0, out_valid = 0, busy = 0, overrun = 0, frame_err = 0, shreg = 0, count = 0, state = IDLE.
- Reset asserted mid-word discards the partial word. After rst deasserts, a frame_start is required before any bit is accepted.
- Latency: out_valid and parallel_out update on the same edge that samples the last bit, and are visible in the following cycle.
- Minimum word time is WIDTH cycles, with frame_start on the first bit's cycle and shift_en held high throughout.
- overrun and frame_err are registered one-cycle pulses, asserted in the cycle after the triggering edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

All scenarios use WIDTH = 4.

- **Basic word:** frame_start with bits 1,1,0,1 on 4 consecutive shift_en cycles -> parallel_out = 4'hB; out_valid rises after the 4th edge; busy is high for cycles 1-3.
- **Gapped input:** same bits with shift_en low for 2 cycles between each bit -> parallel_out = 4'hB; busy stays 1 through the gaps; out_valid is 0 until the 4th bit.
- **Overrun:** receive 4'hB with out_ready = 0, then receive 4'h6 -> parallel_out = 4'h6, out_valid = 1, overrun pulses exactly 1 cycle. Repeat with out_ready = 1 on the completion edge -> no overrun.
- **Frame error:** frame_start, 2 bits, then frame_start with bits 0,0,1,1 -> frame_err pulses once; parallel_out = 4'hC.
- **Reset mid-word:** after 2 bits, pulse rst low -> all outputs are 0 immediately. Then shift_en without frame_start -> ignored; busy = 0.
- **Handshake hold:** after completion, hold out_ready = 0 for 5 cycles -> out_valid and parallel_out are stable. Raise out_ready for 1 cycle -> out_valid = 0 on the next cycle; parallel_out is unchanged.
